// File: rtl/pd_result_reader.sv
// Streams the power-detect result table out of the result RAM with a credit-limited read pipeline,
// tracking a per-antenna peak and a sticky threshold alarm.
module pd_result_reader #(
    parameter int SF_ADDR_NUM = 20,
    parameter int ANT_NUM     = 4,
    parameter int ANW         = 2,
    parameter int SANW        = 5,
    parameter int DW          = 32,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_start,
    input  logic [DW-1:0]           thresh,
    output logic                    rd_en,
    output logic [SANW+ANW-1:0]     rd_addr,
    input  logic [DW-1:0]           rd_data,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [DW-1:0]           o_data,
    output logic [SANW-1:0]         o_sf,
    output logic [ANW-1:0]          o_ant,
    output logic                    o_last,
    output logic [ANT_NUM*DW-1:0]   ant_peak,
    output logic [ANT_NUM-1:0]      ant_alarm,
    output logic                    busy,
    output logic                    done,
    output logic                    start_ovr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [DW-1:0]   data;
        logic [SANW-1:0] sf;
        logic [ANW-1:0]  ant;
        logic            last;
    } entry_t;

    state_t                       state_q;
    logic [SANW-1:0]              sf_q, sf_d;
    logic [ANW-1:0]               ant_q, ant_d;
    logic [DW-1:0]                thresh_q;
    logic [ANT_NUM-1:0][DW-1:0]   peak_q;
    logic [ANT_NUM-1:0]           alarm_q;
    logic                         busy_q, done_q, ovr_q;
    logic [CW-1:0]                outst_q, cnt_q;
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [RD_LAT-1:0]            dl_vld_q, dl_last_q;
    logic [RD_LAT-1:0][SANW-1:0]  dl_sf_q;
    logic [RD_LAT-1:0][ANW-1:0]   dl_ant_q;
    entry_t                       fifo_q [FIFO_DEPTH];
    entry_t                       head;
    logic [CW:0]                  credit_used;
    logic                         issue, last_addr, push, pop;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reads in flight plus words buffered never exceed the FIFO depth, so backpressure cannot lose data.
    assign credit_used = (CW+1)'(outst_q) + (CW+1)'(cnt_q);
    assign issue       = (state_q == READ) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign last_addr   = (sf_q == SANW'(SF_ADDR_NUM - 1)) && (ant_q == ANW'(ANT_NUM - 1));
    assign push        = dl_vld_q[RD_LAT-1];
    assign head        = fifo_q[rd_ptr_q];

    assign rd_en     = issue;
    assign rd_addr   = {sf_q, ant_q};
    assign o_vld     = (cnt_q != '0);
    assign pop       = o_vld & i_rdy;
    assign o_data    = o_vld ? head.data : '0;
    assign o_sf      = o_vld ? head.sf   : '0;
    assign o_ant     = o_vld ? head.ant  : '0;
    assign o_last    = o_vld & head.last;
    assign ant_peak  = peak_q;
    assign ant_alarm = alarm_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign start_ovr = ovr_q;

    always_comb begin
        sf_d  = sf_q;
        ant_d = ant_q + ANW'(1);
        if (ant_q == ANW'(ANT_NUM - 1)) begin
            ant_d = '0;
            sf_d  = (sf_q == SANW'(SF_ADDR_NUM - 1)) ? '0 : sf_q + SANW'(1);
        end
    end

    // Tag delay line matches the RAM latency; clearing it on reset drops any data still in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dl_vld_q  <= '0;
            dl_last_q <= '0;
            dl_sf_q   <= '0;
            dl_ant_q  <= '0;
        end else begin
            dl_vld_q[0]  <= issue;
            dl_last_q[0] <= last_addr;
            dl_sf_q[0]   <= sf_q;
            dl_ant_q[0]  <= ant_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_last_q[i] <= dl_last_q[i-1];
                dl_sf_q[i]   <= dl_sf_q[i-1];
                dl_ant_q[i]  <= dl_ant_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{data: rd_data, sf: dl_sf_q[RD_LAT-1],
                                        ant: dl_ant_q[RD_LAT-1], last: dl_last_q[RD_LAT-1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            outst_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_nxt(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_nxt(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            case ({issue, push})
                2'b10:   outst_q <= outst_q + CW'(1);
                2'b01:   outst_q <= outst_q - CW'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            sf_q     <= '0;
            ant_q    <= '0;
            thresh_q <= '0;
            peak_q   <= '0;
            alarm_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rd_start && state_q != IDLE) ovr_q <= 1'b1;
            if (pop) begin
                for (int a = 0; a < ANT_NUM; a++) begin
                    if (o_ant == ANW'(a)) begin
                        if (o_data > peak_q[a]) peak_q[a] <= o_data;
                        if (o_data > thresh_q)  alarm_q[a] <= 1'b1;
                    end
                end
            end
            case (state_q)
                IDLE: if (rd_start) begin
                    state_q  <= READ;
                    busy_q   <= 1'b1;
                    thresh_q <= thresh;
                    peak_q   <= '0;
                    alarm_q  <= '0;
                    sf_q     <= '0;
                    ant_q    <= '0;
                end
                READ: if (issue) begin
                    sf_q  <= sf_d;
                    ant_q <= ant_d;
                    if (last_addr) state_q <= DRAIN;
                end
                DRAIN: if (pop && o_last) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pd_result_reader.sv
// Directed bench for pd_result_reader: table of whole-table reads plus start-while-busy and reset-abort sequences.
module tb_pd_result_reader;
    logic         clk, reset, rd_start, rd_en, i_rdy, o_vld, o_last, busy, done, start_ovr;
    logic [31:0]  thresh, rd_data, o_data;
    logic [6:0]   rd_addr;
    logic [4:0]   o_sf;
    logic [1:0]   o_ant;
    logic [127:0] ant_peak;
    logic [3:0]   ant_alarm;

    pd_result_reader dut (
        .clk(clk), .reset(reset), .rd_start(rd_start), .thresh(thresh),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_data(o_data), .o_sf(o_sf), .o_ant(o_ant),
        .o_last(o_last), .ant_peak(ant_peak), .ant_alarm(ant_alarm),
        .busy(busy), .done(done), .start_ovr(start_ovr)
    );

    typedef struct {
        int          mode;
        logic [31:0] th;
        int          rdy;
        logic [3:0][31:0] peak;
        logic [3:0]  alarm;
    } vec_t;

    vec_t tbl [7];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, ram_mode = 0, rdy_mode = 0;
    bit run_on = 0;
    int issued_n, popped_n, done_n, first_rden, first_vld, first_pop, last_pop, done_cyc;
    logic [31:0] ram_p1, ram_p2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ram_fn(input int mode, input int sf, input int ant);
        case (mode)
            0:       return 32'(sf * 4 + ant);
            1:       return (ant == 2 && sf == 7) ? 32'h100 : 32'h10;
            default: return 32'h10;
        endcase
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data RD_LAT=2 cycles after the address is presented
    always @(posedge clk) begin
        ram_p1 <= ram_fn(ram_mode, int'(rd_addr[6:2]), int'(rd_addr[1:0]));
        ram_p2 <= ram_p1;
    end
    assign rd_data = ram_p2;

    initial begin
        i_rdy = 1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       i_rdy = 1;
                1:       i_rdy = !((cyc - start_cyc) >= 5 && (cyc - start_cyc) <= 20);
                default: i_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: issue rule, address order and every popped beat
    always @(negedge clk) begin
        int infl;
        infl = issued_n - popped_n;
        chk("rd_en_credit", rd_en, (run_on && cyc > start_cyc && issued_n < 80 && infl < 4));
        if (rd_en) begin
            chk("rd_addr", rd_addr, issued_n);
            if (first_rden < 0) first_rden = cyc;
            issued_n++;
        end
        if (o_vld && first_vld < 0) first_vld = cyc;
        if (o_vld && i_rdy) begin
            chk("o_data", o_data, ram_fn(ram_mode, popped_n / 4, popped_n % 4));
            chk("o_sf", o_sf, popped_n / 4);
            chk("o_ant", o_ant, popped_n % 4);
            chk("o_last", o_last, popped_n == 79);
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            popped_n++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic begin_run(input int mode, input logic [31:0] th, input int rdy);
        @(posedge clk); #1;
        ram_mode = mode; thresh = th; rdy_mode = rdy;
        issued_n = 0; popped_n = 0; done_n = 0;
        first_rden = -1; first_vld = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
        rd_start = 1; start_cyc = cyc; run_on = 1;
    endtask

    task automatic run_vec(input vec_t v, input int ovr_at);
        bit got;
        begin_run(v.mode, v.th, v.rdy);
        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            rd_start = (ovr_at > 0 && (cyc - start_cyc) == ovr_at);
            if (k == 0) thresh = ~v.th;  // must have been latched at start
            @(negedge clk);
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
        chk("busy_at_done", busy, 1);
        @(posedge clk); #1; rd_start = 0;
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_after", busy, 0);
        chk("vld_after", o_vld, 0);
        chk("beats", popped_n, 80);
        chk("done_pulses", done_n, 1);
        chk("done_after_last_pop", done_cyc - last_pop, 1);
        chk("ant_peak", ant_peak, v.peak);
        chk("ant_alarm", ant_alarm, v.alarm);
        if (v.rdy == 0) begin
            chk("first_rd_en_cyc", first_rden - start_cyc, 1);
            chk("first_vld_cyc", first_vld - start_cyc, 4);
            chk("no_bubbles", last_pop - first_pop, 79);
        end
        run_on = 0;
    endtask

    initial begin
        tbl[0] = '{0, 32'd77,    0, {32'd79, 32'd78, 32'd77, 32'd76},         4'b1100};
        tbl[1] = '{0, 32'd0,     1, {32'd79, 32'd78, 32'd77, 32'd76},         4'b1111};
        tbl[2] = '{1, 32'h80,    0, {32'h10, 32'h100, 32'h10, 32'h10},        4'b0100};
        tbl[3] = '{2, 32'h80,    0, {32'h10, 32'h10, 32'h10, 32'h10},         4'b0000};
        tbl[4] = '{0, 32'd78,    2, {32'd79, 32'd78, 32'd77, 32'd76},         4'b1000};
        tbl[5] = '{1, 32'h100,   2, {32'h10, 32'h100, 32'h10, 32'h10},        4'b0000};
        tbl[6] = '{0, 32'd78,    2, {32'd79, 32'd78, 32'd77, 32'd76},         4'b1000};
        issued_n = 0; popped_n = 0; done_n = 0;
        first_rden = -1; first_vld = -1; first_pop = -1; last_pop = -1; done_cyc = -1;

        reset = 0; rd_start = 0; thresh = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_o_vld", o_vld, 0);
        chk("rst_outs", {o_data, o_sf, o_ant, o_last}, 0);
        chk("rst_flags", {busy, done, start_ovr, ant_alarm}, 0);
        chk("rst_peak", ant_peak, 0);
        @(posedge clk); #1 reset = 1;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], -1);
        chk("ovr_clear", start_ovr, 0);

        run_vec(tbl[0], 30);
        chk("ovr_set", start_ovr, 1);

        // Abort a read with a one-cycle reset at cycle 40
        begin_run(0, 32'd0, 0);
        @(posedge clk); #1 rd_start = 0;
        repeat (39) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1 reset = 1; run_on = 0;
        @(negedge clk);
        chk("abort_rd_en", {rd_en, rd_addr}, 0);
        chk("abort_o_vld", o_vld, 0);
        chk("abort_outs", {o_data, o_sf, o_ant, o_last}, 0);
        chk("abort_flags", {busy, done, start_ovr, ant_alarm}, 0);
        chk("abort_peak", ant_peak, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_idle_vld", o_vld, 0);
        end
        run_vec(tbl[0], -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
